// File: rtl/ntt_agu_param.sv
// NTT/INTT butterfly and twiddle address generator.
// Issues LANES butterflies per beat under a valid/ready handshake.
module ntt_agu_param #(
  parameter int LOGN  = 8,
  parameter int LANES = 1,
  parameter int AW    = LOGN,
  parameter int ZW    = LOGN - 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                is_ntt,
  input  logic                clear,
  input  logic                ready,
  output logic                valid,
  output logic [LANES*AW-1:0] addr_j,
  output logic [LANES*AW-1:0] addr_jl,
  output logic [ZW-1:0]       addr_zetas,
  output logic [3:0]          layer,
  output logic                last,
  output logic                busy,
  output logic                done
);

  localparam int N = 1 << LOGN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  logic            mode;
  logic [AW-1:0]   j;
  logic [AW-1:0]   len;
  logic [ZW-1:0]   k;
  logic [3:0]      lyr;

  logic [AW:0]     jn;
  logic [AW:0]     jnext;
  logic            blk_end;
  logic            lay_end;
  logic            fin;
  logic            run;

  // a block ends when the next j would cross into the upper half
  assign jn      = {1'b0, j} + (AW+1)'(LANES);
  assign jnext   = jn + {1'b0, len};
  assign blk_end = (jn[AW-1:0] & (len - AW'(1))) == '0;
  assign lay_end = blk_end && (jnext == (AW+1)'(N));
  assign fin     = lay_end && (lyr == 4'(LOGN - 2));
  assign run     = (state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mode  <= 1'b0;
      j     <= '0;
      len   <= '0;
      k     <= '0;
      lyr   <= '0;
    end else if (clear) begin
      state <= S_IDLE;
      mode  <= 1'b0;
      j     <= '0;
      len   <= '0;
      k     <= '0;
      lyr   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            mode  <= is_ntt;
            j     <= '0;
            lyr   <= '0;
            len   <= is_ntt ? AW'(N / 2) : AW'(2);
            k     <= is_ntt ? ZW'(1) : ZW'(N / 2 - 1);
          end
        end
        S_RUN: begin
          if (ready) begin
            if (fin) begin
              state <= S_DONE;
            end else begin
              if (lay_end) begin
                j   <= '0;
                lyr <= lyr + 4'd1;
                len <= mode ? (len >> 1) : (len << 1);
              end else if (blk_end) begin
                j <= jnext[AW-1:0];
              end else begin
                j <= jn[AW-1:0];
              end
              if (blk_end)
                k <= mode ? k + ZW'(1) : k - ZW'(1);
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign valid      = run;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign last       = run && fin;
  assign layer      = run ? lyr : 4'd0;
  assign addr_zetas = run ? k : '0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign addr_j[g*AW +: AW]  = run ? j + AW'(g) : '0;
    assign addr_jl[g*AW +: AW] = run ? j + AW'(g) + len : '0;
  end

endmodule

// File: tb/tb_ntt_agu_param.sv
// Scoreboard bench for ntt_agu_param.
// Three instances: N=256 x1, N=256 x2, N=16 x1.
module tb_ntt_agu_param;

  typedef struct packed {
    logic [7:0] j0;
    logic [7:0] jl0;
    logic [7:0] j1;
    logic [7:0] jl1;
    logic [6:0] z;
    logic [3:0] ly;
    logic       ls;
  } beat_t;

  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic is_ntt = 0;
  logic clear = 0;
  logic ready = 1;
  logic start_o = 0;
  logic clear_o = 0;
  logic ready_o = 1;

  logic       v8, ls8, bz8, d8;
  logic [7:0] aj8, ajl8;
  logic [6:0] z8;
  logic [3:0] ly8;

  logic        v2, ls2, bz2, d2;
  logic [15:0] aj2, ajl2;
  logic [6:0]  z2;
  logic [3:0]  ly2;

  logic       v4, ls4, bz4, d4;
  logic [3:0] aj4, ajl4;
  logic [2:0] z4;
  logic [3:0] ly4;

  int n_cmp = 0;
  int n_err = 0;

  beat_t mq[$];
  beat_t q8[$];
  beat_t q2[$];
  beat_t q4[$];
  beat_t cap8[4096];
  beat_t cap2[1024];
  beat_t cap4[256];
  int acc8 = 0, acc2 = 0, acc4 = 0;
  int dc8 = 0, dc2 = 0, dc4 = 0;
  logic [30:0] snap;
  bit pst = 0;

  always #5 clk = ~clk;

  ntt_agu_param #(.LOGN(8), .LANES(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .is_ntt(is_ntt),
    .clear(clear), .ready(ready), .valid(v8), .addr_j(aj8),
    .addr_jl(ajl8), .addr_zetas(z8), .layer(ly8), .last(ls8),
    .busy(bz8), .done(d8)
  );

  ntt_agu_param #(.LOGN(8), .LANES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_o), .is_ntt(1'b1),
    .clear(clear_o), .ready(ready_o), .valid(v2), .addr_j(aj2),
    .addr_jl(ajl2), .addr_zetas(z2), .layer(ly2), .last(ls2),
    .busy(bz2), .done(d2)
  );

  ntt_agu_param #(.LOGN(4), .LANES(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_o), .is_ntt(1'b1),
    .clear(clear_o), .ready(ready_o), .valid(v4), .addr_j(aj4),
    .addr_jl(ajl4), .addr_zetas(z4), .layer(ly4), .last(ls4),
    .busy(bz4), .done(d4)
  );

  wire [30:0] out8 = {v8, aj8, ajl8, z8, ly8, ls8, bz8, d8};

  function automatic beat_t mk(input int a, b, c, d, z, l, s);
    beat_t e;
    e.j0 = 8'(a);
    e.jl0 = 8'(b);
    e.j1 = 8'(c);
    e.jl1 = 8'(d);
    e.z = 7'(z);
    e.ly = 4'(l);
    e.ls = 1'(s);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference schedule built from layer/block/butterfly loops
  task automatic gen(input int logn, input int lanes, input bit ntt);
    int n, len, k, nb, j;
    mq.delete();
    n = 1 << logn;
    k = ntt ? 1 : n / 2 - 1;
    for (int l = 0; l < logn - 1; l++) begin
      len = ntt ? (n >> (l + 1)) : (2 << l);
      nb = n / (2 * len);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < len; i += lanes) begin
          j = b * 2 * len + i;
          mq.push_back(mk(j, j + len,
            lanes == 2 ? j + 1 : 0,
            lanes == 2 ? j + 1 + len : 0, k, l,
            (l == logn - 2) && (b == nb - 1) && (i + lanes >= len)));
        end
        k = ntt ? k + 1 : k - 1;
      end
    end
  endtask

  always @(negedge clk) begin
    beat_t g;
    if (v8 && ready) begin
      g = mk(aj8, ajl8, 0, 0, z8, ly8, ls8);
      cap8[acc8] = g;
      acc8++;
      if (q8.size() == 0) chk("u8_extra_beat", g, 0);
      else chk("u8_beat", g, q8.pop_front());
    end
    if (v8 && !ready) begin
      if (pst) chk("u8_stall_hold", out8, snap);
      snap = out8;
      pst = 1;
    end else begin
      pst = 0;
    end
    if (d8) dc8++;
    if (v2 && ready_o) begin
      g = mk(aj2[7:0], ajl2[7:0], aj2[15:8], ajl2[15:8], z2, ly2, ls2);
      cap2[acc2 % 1024] = g;
      acc2++;
      if (q2.size() == 0) chk("u2_extra_beat", g, 0);
      else chk("u2_beat", g, q2.pop_front());
    end
    if (d2) dc2++;
    if (v4 && ready_o) begin
      g = mk(aj4, ajl4, 0, 0, z4, ly4, ls4);
      cap4[acc4 % 256] = g;
      acc4++;
      if (q4.size() == 0) chk("u4_extra_beat", g, 0);
      else chk("u4_beat", g, q4.pop_front());
    end
    if (d4) dc4++;
  end

  task automatic run8(input bit ntt, input int st_at, input int pk_at,
                      input int cl_at, input int rs_at, output int base);
    int dbase, nexp, cyc, bi;
    bit stalled, poked, ended;
    gen(8, 1, ntt);
    nexp = (cl_at >= 0) ? cl_at : (rs_at >= 0) ? rs_at : mq.size();
    q8.delete();
    for (int i = 0; i < nexp; i++) q8.push_back(mq[i]);
    base = acc8;
    dbase = dc8;
    stalled = 0;
    poked = 0;
    ended = 0;
    cyc = 0;
    @(posedge clk); #1;
    start = 1;
    is_ntt = ntt;
    @(posedge clk); #1;
    start = 0;
    is_ntt = !ntt;
    while (!ended && cyc < 2000) begin
      bi = acc8 - base;
      if (dc8 != dbase) begin
        ended = 1;
      end else if (bi == st_at && !stalled) begin
        stalled = 1;
        ready = 0;
        repeat (5) @(posedge clk);
        #1 ready = 1;
      end else if (bi == pk_at && !poked) begin
        poked = 1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
      end else if (bi == cl_at) begin
        clear = 1;
        ready = 0;
        @(posedge clk); #1;
        clear = 0;
        ready = 1;
        chk("clear_to_idle", {v8, bz8, d8}, 0);
        ended = 1;
      end else if (bi == rs_at) begin
        rst_n = 0;
        #1 chk("rst_mid_run", out8, 0);
        #2 rst_n = 1;
        ended = 1;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    chk("run_terminated", ended, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("done_pulses", dc8 - dbase,
        (cl_at < 0 && rs_at < 0) ? 1 : 0);
    chk("beats_accepted", acc8 - base, nexp);
    chk("queue_drained", q8.size(), 0);
    chk("idle_after", {v8, bz8, d8}, 0);
  endtask

  initial begin
    int b, b2, b4, cyc;
    #3 chk("reset_outputs", out8, 0);
    #4 rst_n = 1;

    run8(1, 10, 50, -1, -1, b);
    chk("ntt_b0", cap8[b], mk(0, 128, 0, 0, 1, 0, 0));
    chk("ntt_b127", cap8[b + 127], mk(127, 255, 0, 0, 1, 0, 0));
    chk("ntt_b128", cap8[b + 128], mk(0, 64, 0, 0, 2, 1, 0));
    chk("ntt_b192", cap8[b + 192], mk(128, 192, 0, 0, 3, 1, 0));
    chk("ntt_b895", cap8[b + 895], mk(253, 255, 0, 0, 127, 6, 1));

    run8(0, -1, -1, -1, -1, b);
    chk("intt_b0", cap8[b], mk(0, 2, 0, 0, 127, 0, 0));
    chk("intt_b1", cap8[b + 1], mk(1, 3, 0, 0, 127, 0, 0));
    chk("intt_b2", cap8[b + 2], mk(4, 6, 0, 0, 126, 0, 0));
    chk("intt_b895", cap8[b + 895], mk(127, 255, 0, 0, 1, 6, 1));

    run8(1, -1, -1, 300, -1, b);
    @(posedge clk); #1;
    start = 1;
    clear = 1;
    @(posedge clk); #1;
    start = 0;
    clear = 0;
    chk("start_clear_same", {v8, bz8}, 0);

    run8(1, -1, -1, -1, 400, b);

    gen(8, 2, 1);
    q2 = mq;
    gen(4, 1, 1);
    q4 = mq;
    b2 = acc2;
    b4 = acc4;
    @(posedge clk); #1;
    start_o = 1;
    @(posedge clk); #1;
    start_o = 0;
    cyc = 0;
    while ((dc2 == 0 || dc4 == 0) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("wide_runs_done", {dc2 == 1, dc4 == 1}, 2'b11);
    repeat (3) @(posedge clk);
    #1;
    chk("x2_beats", acc2 - b2, 448);
    chk("x2_b0", cap2[b2], mk(0, 128, 1, 129, 1, 0, 0));
    chk("x2_b447", cap2[b2 + 447], mk(252, 254, 253, 255, 127, 6, 1));
    chk("n16_beats", acc4 - b4, 24);
    chk("n16_b0", cap4[b4], mk(0, 8, 0, 0, 1, 0, 0));
    chk("n16_b23", cap4[b4 + 23], mk(13, 15, 0, 0, 7, 2, 1));
    chk("wide_done_once", {dc2, dc4}, {32'd1, 32'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
